main_memory_controller: RTL and testbench
=========================================

// Module: main_memory_controller
// PURPOSE
// - Line-granular memory slave on the far side of the CPU's external memory bus.
// - Serves cache-line read/fill and write-back requests forwarded by the MMU
//   for the instruction and data caches.
// - Applies a fixed, programmable access latency.
// - Used as the system memory in simulation and as the model for the FPGA BRAM
//   controller.
// PARAMETERS
// - XLEN        32    address width
// - LINE_WORDS  4     32-bit words per cache line (power of 2, >=1)
// - MEM_LINES   1024  storage depth in lines (power of 2)
// - LATENCY     4     cycles from request accept to resp_valid (>=1)
// PORTS
// - clk         in   1                clock, all logic on rising edge
// - reset       in   1                synchronous, active-high
// - req_valid   in   1                request present
// - req_write   in   1                1 = line write, 0 = line read
// - req_addr    in   XLEN             byte address; offset bits ignored
// - req_wdata   in   LINE_WORDS*32    write line, word 0 in LSBs
// - req_ready   out  1                controller can accept a request
// - resp_valid  out  1                response present
// - resp_rdata  out  LINE_WORDS*32    read line; 0 for write responses
// - resp_error  out  1                address out of range (MAIN_MEM_ERR_EN only)
// - resp_ready  in   1                requester accepts response
// BEHAVIOUR
// - Reset: state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0,
//   latency counter=0. Storage is NOT cleared.
// - Reset mid-operation: abort, return to IDLE, drop any pending response.
//   A write already committed stays committed.
// - Line index = req_addr[OFS+LIDX-1:OFS].
//   OFS = log2(LINE_WORDS*4); LIDX = log2(MEM_LINES).
// - Upper address bits: ignored (wrap) unless MAIN_MEM_ERR_EN is defined.
// - FSM IDLE -> WAIT: on req_valid && req_ready.
//   - Latch req_write, index and wdata.
//   - Load counter with LATENCY-1.
//   - Writes commit to storage on this accept edge.
// - FSM WAIT: decrement counter each cycle. When counter == 0, go to RESP
//   (same edge).
//   - Reads sample storage on that edge into resp_rdata.
// - FSM RESP: resp_valid=1. Outputs stay stable until resp_valid && resp_ready.
//   On the handshake edge go to IDLE; resp_valid drops next cycle.
// - req_ready=1 only in IDLE, so at most one request is outstanding.
//   req_* is ignored when req_ready=0.
// - Latency: accept at edge N gives resp_valid high from cycle N+LATENCY.
//   With LATENCY=1, WAIT is passed in a single cycle.
// - Back-to-back requests: after the RESP handshake, one IDLE cycle is needed
//   before the next accept. Minimum period is LATENCY+2 cycles.
// - Read after write to the same line returns the new data, because the write
//   commits at accept.
// - req_valid held high during RESP is not accepted until IDLE.
// CONFIGURATION
// - MAIN_MEM_ERR_EN defined:
//   - If req_addr[XLEN-1:OFS+LIDX] != 0, the request is flagged.
//   - A flagged write is not committed.
//   - A flagged read returns resp_rdata=0.
//   - resp_error=1 together with resp_valid. Timing is unchanged.
// - MAIN_MEM_ERR_EN undefined:
//   - Upper bits are ignored, so the address wraps modulo the storage size.
//   - resp_error is tied to 0.
// TESTING
// - Reset, then idle 5 cycles -> req_ready=1, resp_valid=0, resp_error=0.
// - Write line 0x40 = {4,3,2,1} words, accept at cycle 10
//   -> resp_valid at cycle 14, resp_rdata=0.
//   Then read 0x40 -> {4,3,2,1}.
// - Read 0x48 (offset bits set) after that write -> same line {4,3,2,1}.
//   Offset bits are ignored.
// - Hold resp_ready=0 for 3 cycles in RESP -> resp_valid and resp_rdata stable,
//   req_ready=0 throughout.
//   Raise resp_ready -> IDLE after 1 cycle.
// - Assert reset in WAIT at counter=2 -> next cycle IDLE, req_ready=1,
//   no resp_valid ever seen for that request.
// - Address 0x0001_0000 with MEM_LINES=1024, LINE_WORDS=4
//   (OFS=4, LIDX=10, so bits 31:14 are nonzero):
//   - Macro defined: resp_error=1, rdata=0, no write.
//   - Macro undefined: aliases to line 0.

Source files
------------

// File: rtl/main_memory_controller.sv
// Line-granular memory slave: one outstanding line read/write, fixed LATENCY.
// Optional feature: MAIN_MEM_ERR_EN flags addresses beyond the storage size.
module main_memory_controller #(
   parameter int XLEN       = 32,
   parameter int LINE_WORDS = 4,
   parameter int MEM_LINES  = 1024,
   parameter int LATENCY    = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       req_valid,
   input  logic                       req_write,
   input  logic [XLEN-1:0]            req_addr,
   input  logic [LINE_WORDS*32-1:0]   req_wdata,
   output logic                       req_ready,
   output logic                       resp_valid,
   output logic [LINE_WORDS*32-1:0]   resp_rdata,
   output logic                       resp_error,
   input  logic                       resp_ready
);

   localparam int LINE_W = LINE_WORDS * 32;
   localparam int OFS    = $clog2(LINE_WORDS * 4);
   localparam int LIDX   = $clog2(MEM_LINES);
   localparam int CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              wr_q;
   logic              err_q;
   logic [LIDX-1:0]   idx_q;
   logic [LIDX-1:0]   req_idx;
   logic              req_err;
   logic              accept;
   logic              unused_addr_bits;
   logic [LINE_W-1:0] mem [MEM_LINES];

   assign req_idx = req_addr[OFS+LIDX-1:OFS];
   assign accept  = req_valid && req_ready;

`ifdef MAIN_MEM_ERR_EN
   assign req_err          = |req_addr[XLEN-1:OFS+LIDX];
   assign resp_error       = resp_valid && err_q;
   assign unused_addr_bits = ^req_addr[OFS-1:0];
`else
   // Upper address bits are dropped, so the storage aliases modulo its size.
   assign req_err          = 1'b0;
   assign resp_error       = 1'b0;
   assign unused_addr_bits = ^{req_addr[XLEN-1:OFS+LIDX], req_addr[OFS-1:0]};
`endif

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // NOTE: every signal written here gets a default first; a missed branch
   // would otherwise infer a latch.
   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt == '0) state_nxt = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt        <= '0;
         wr_q       <= 1'b0;
         err_q      <= 1'b0;
         idx_q      <= '0;
         resp_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  wr_q  <= req_write;
                  err_q <= req_err;
                  idx_q <= req_idx;
                  cnt   <= CNT_W'(LATENCY - 1);
               end
            end
            WAIT: begin
               if (cnt == '0) resp_rdata <= (wr_q || err_q) ? '0 : mem[idx_q];
               else           cnt        <= cnt - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // NOTE: the storage array has no reset; clearing it would prevent BRAM
   // inference, and its contents must survive a controller reset anyway.
   // Writes commit on the accept edge, so read-after-write sees new data.
   always_ff @(posedge clk) begin
      if (accept && req_write && !req_err && !reset) mem[req_idx] <= req_wdata;
   end

endmodule

// File: tb/tb_main_memory_controller.sv
// Scoreboard bench for main_memory_controller: randomized and directed line
// traffic checked against an associative-array memory model.
module tb_main_memory_controller;

   localparam int XLEN       = 32;
   localparam int LINE_WORDS = 4;
   localparam int MEM_LINES  = 1024;
   localparam int LATENCY    = 4;
   localparam int LW         = LINE_WORDS * 32;
   localparam int OFS        = 4;
   localparam int LIDX       = 10;
`ifdef MAIN_MEM_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic            clk;
   logic            reset;
   logic            req_valid;
   logic            req_write;
   logic [XLEN-1:0] req_addr;
   logic [LW-1:0]   req_wdata;
   logic            req_ready;
   logic            resp_valid;
   logic [LW-1:0]   resp_rdata;
   logic            resp_error;
   logic            resp_ready;

   main_memory_controller #(
      .XLEN(XLEN), .LINE_WORDS(LINE_WORDS), .MEM_LINES(MEM_LINES), .LATENCY(LATENCY)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
      .resp_ready(resp_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [LW-1:0] rdata;
      logic          err;
      int            vcyc;
   } exp_t;

   exp_t          sb[$];
   logic [LW-1:0] model_mem [int];
   int            vectors = 0;
   int            miscompares = 0;
   int            done_cnt = 0;
   int            issued = 0;
   int            hold_cnt = 0;

   task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic flag(input string name);
      vectors++;
      miscompares++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   function automatic int line_of(input logic [31:0] a);
      return int'((a >> OFS) % MEM_LINES);
   endfunction

   function automatic bit err_of(input logic [31:0] a);
      return ERR_EN && ((a >> (OFS + LIDX)) != 0);
   endfunction

   // Reference: a line store addressed by (addr / line bytes) mod depth.
   task automatic predict(input bit w, input logic [31:0] a, input logic [LW-1:0] d);
      exp_t e;
      e.err  = err_of(a);
      e.vcyc = cyc + 1 + LATENCY;
      if (w) begin
         if (!e.err) model_mem[line_of(a)] = d;
         e.rdata = '0;
      end else if (e.err) begin
         e.rdata = '0;
      end else begin
         e.rdata = model_mem[line_of(a)];
      end
      sb.push_back(e);
      issued++;
   endtask

   // resp_ready changes #1 after the edge so the monitor sees it settled.
   initial begin
      bit force_hi;
      force_hi   = 1'b0;
      resp_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         if (hold_cnt > 0 && resp_valid) begin
            resp_ready = 1'b0;
            hold_cnt--;
            force_hi = (hold_cnt == 0);
         end else if (force_hi) begin
            resp_ready = 1'b1;
            force_hi   = 1'b0;
         end else begin
            resp_ready = ($urandom % 4) != 0;
         end
      end
   end

   // Monitor: pops one expectation per response and re-checks it each held cycle.
   initial begin
      bit   in_resp;
      bit   idle_next;
      exp_t cur;
      in_resp   = 1'b0;
      idle_next = 1'b0;
      forever begin
         @(negedge clk);
         if (reset) begin
            in_resp   = 1'b0;
            idle_next = 1'b0;
         end else if (resp_valid) begin
            if (!in_resp) begin
               if (sb.size() == 0) begin
                  flag("unexpected_resp_valid");
               end else begin
                  cur = sb.pop_front();
                  check("latency", LW'(cyc), LW'(cur.vcyc));
                  in_resp = 1'b1;
               end
            end
            if (in_resp) begin
               check("resp_rdata", resp_rdata, cur.rdata);
               check("resp_error", LW'(resp_error), LW'(cur.err));
               check("req_ready_busy", LW'(req_ready), '0);
               if (resp_ready) begin
                  in_resp   = 1'b0;
                  idle_next = 1'b1;
                  done_cnt++;
               end
            end
         end else begin
            if (in_resp) begin
               check("resp_valid_held", LW'(resp_valid), LW'(1));
               in_resp = 1'b0;
            end
            if (idle_next) begin
               check("idle_after_handshake", LW'(req_ready), LW'(1));
               idle_next = 1'b0;
            end
         end
      end
   end

   // Called and returns at a negedge; holds ignored garbage while busy.
   task automatic do_req(input bit w, input logic [31:0] a, input logic [LW-1:0] d);
      int i;
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      for (i = 0; i < 50 && !req_ready; i++) @(negedge clk);
      if (!req_ready) begin
         flag("req_ready_timeout");
         req_valid = 1'b0;
         return;
      end
      predict(w, a, d);
      @(negedge clk);
      req_write = 1'($urandom % 2);
      req_addr  = ($urandom_range(0, 7) << OFS) | ($urandom & 32'hF);
      req_wdata = {$urandom, $urandom, $urandom, $urandom};
      for (i = 0; i < 200 && done_cnt < issued; i++) @(posedge clk);
      if (done_cnt < issued) flag("resp_timeout");
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   initial begin
      logic [LW-1:0] d1;
      logic [LW-1:0] dr;
      logic [31:0]   a;
      bit            w;

      reset     = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (5) @(negedge clk);
      check("reset_req_ready", LW'(req_ready), LW'(1));
      check("reset_resp_valid", LW'(resp_valid), '0);
      check("reset_resp_error", LW'(resp_error), '0);
      check("reset_resp_rdata", resp_rdata, '0);

      d1 = {32'd4, 32'd3, 32'd2, 32'd1};
      do_req(1'b1, 32'h40, d1);
      do_req(1'b0, 32'h40, '0);
      do_req(1'b0, 32'h48, '0);

      hold_cnt = 3;
      do_req(1'b0, 32'h40, '0);

      // Abort a write in WAIT with the counter at 2; the write stays committed.
      dr = {$urandom, $urandom, $urandom, $urandom};
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h30;
      req_wdata = dr;
      check("abort_req_ready", LW'(req_ready), LW'(1));
      model_mem[line_of(32'h30)] = dr;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_idle_ready", LW'(req_ready), LW'(1));
      check("abort_no_resp", LW'(resp_valid), '0);
      repeat (10) @(negedge clk);
      do_req(1'b0, 32'h30, '0);

      // Out-of-range address: error response or alias onto line 0.
      do_req(1'b1, 32'h0, {$urandom, $urandom, $urandom, $urandom});
      do_req(1'b1, 32'h0001_0000, {$urandom, $urandom, $urandom, $urandom});
      do_req(1'b0, 32'h0, '0);
      do_req(1'b0, 32'h0001_0000, '0);

      for (int t = 0; t < 60; t++) begin
         a = ($urandom_range(0, 7) << OFS) | ($urandom & 32'hF);
         if ($urandom % 8 == 0) a = a | ($urandom_range(1, 255) << (OFS + LIDX));
         w = !model_mem.exists(line_of(a)) || ($urandom % 2 == 1);
         if (err_of(a)) w = 1'($urandom % 2);
         do_req(w, a, {$urandom, $urandom, $urandom, $urandom});
      end

      repeat (10) @(negedge clk);
      check("scoreboard_drained", LW'(sb.size()), '0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
